// File: rtl/encoder_4_2_seq_if.sv
// Event-encoder bus: capture inputs, encoded index output and its valid/ready handshake.
interface encoder_4_2_seq_if;
  logic       en;
  logic [0:3] in;
  logic       ready;
  logic       a;
  logic       b;
  logic       valid;
  logic       ovf;

  modport master (output en, in, ready, input a, b, valid, ovf);
  modport slave  (input en, in, ready, output a, b, valid, ovf);
endinterface

// File: rtl/encoder_4_2_seq.sv
// Sequential 4:2 priority encoder: latches events into a pending mask and serves
// them lowest-index-first through a registered valid/ready output stage.
module encoder_4_2_seq (
  input  logic                clk,
  input  logic                rst_n,
  encoder_4_2_seq_if.slave    bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0] state, state_nxt;
  logic [0:3] pend, pend_nxt, cap, clr;
  logic [1:0] sel, idx;
  logic       has_pend, load, accept, ovf_r, ovf_set;

  // Selection looks only at registered pend, never at the live inputs.
  always_comb begin
    if (pend[0])      sel = 2'd0;
    else if (pend[1]) sel = 2'd1;
    else if (pend[2]) sel = 2'd2;
    else              sel = 2'd3;
  end

  always_comb begin
    has_pend = |pend;
    accept   = (state == S_HOLD) && bus.ready;
    load     = ((state == S_IDLE) || bus.ready) && has_pend;
    cap      = bus.en ? bus.in : 4'b0000;
    clr      = 4'b0000;
    if (load) clr[sel] = 1'b1;
    // Capture is OR-ed in after the clear, so a same-edge re-arrival stays pending.
    pend_nxt = (pend & ~clr) | cap;
    ovf_set  = |(cap & pend & ~clr);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load) state_nxt = S_HOLD;
      S_HOLD:  if (accept && !has_pend) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pend  <= 4'b0000;
      idx   <= 2'd0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (load)    idx   <= sel;
      if (ovf_set) ovf_r <= 1'b1;
    end
  end

  assign bus.a     = idx[0];
  assign bus.b     = idx[1];
  assign bus.valid = (state == S_HOLD);
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_encoder_4_2_seq.sv
// Bench for encoder_4_2_seq: vector table, directed corner sequences, then
// random traffic against a pending-set reference model.
module tb_encoder_4_2_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  encoder_4_2_seq_if bus ();

  encoder_4_2_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [0:3] in;
    logic       rdy;
    logic       exp_vld;
    logic [1:0] exp_idx;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[17];
  int total = 0;
  int bad   = 0;

  // Reference model: a set of pending indices plus the presented output.
  bit m_pend[4];
  bit m_vld;
  bit m_ovf;
  int m_idx;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int dut_idx();
    return {bus.b, bus.a};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_pend[k] = 0;
    m_vld = 0;
    m_ovf = 0;
    m_idx = 0;
  endtask

  task automatic model_step(input logic e, input logic [0:3] i, input logic r);
    int  first;
    bit  ld;
    first = -1;
    for (int k = 3; k >= 0; k--) if (m_pend[k]) first = k;
    ld = (!m_vld || r) && (first >= 0);
    for (int k = 0; k < 4; k++) begin
      bit gone;
      gone = ld && (k == first);
      if (e && i[k]) begin
        if (m_pend[k] && !gone) m_ovf = 1;
        m_pend[k] = 1;
      end else if (gone) begin
        m_pend[k] = 0;
      end
    end
    if (ld) begin
      m_idx = first;
      m_vld = 1;
    end else if (m_vld && r) begin
      m_vld = 0;
    end
  endtask

  // Drive at the negedge, advance one rising edge, compare at the next negedge.
  task automatic cycle(input logic e, input logic [0:3] i, input logic r);
    bus.en    = e;
    bus.in    = i;
    bus.ready = r;
    @(posedge clk);
    model_step(e, i, r);
    @(negedge clk);
    chk("mdl_valid", bus.valid, m_vld);
    chk("mdl_idx",   dut_idx(), m_idx);
    chk("mdl_ovf",   bus.ovf,   m_ovf);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.in    = 4'b0000;
    bus.ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid, 0);
    chk("rst_idx",   dut_idx(), 0);
    chk("rst_ovf",   bus.ovf,   0);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[12] = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[13] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0};

    bus.en = 1'b0; bus.in = 4'b0000; bus.ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Single event, multi-hot with stall, priority override.
    for (int n = 0; n < 17; n++) begin
      cycle(tbl[n].en, tbl[n].in, tbl[n].rdy);
      chk($sformatf("tbl%0d_valid", n), bus.valid, tbl[n].exp_vld);
      chk($sformatf("tbl%0d_idx", n),   dut_idx(), tbl[n].exp_idx);
      chk($sformatf("tbl%0d_ovf", n),   bus.ovf,   tbl[n].exp_ovf);
    end

    // Overflow: duplicate index 1 while it is still pending.
    cycle(1'b1, 4'b1000, 1'b0); chk("ov_v0", bus.valid, 0);
    cycle(1'b1, 4'b0100, 1'b0); chk("ov_i0", dut_idx(), 0); chk("ov_o0", bus.ovf, 0);
    cycle(1'b1, 4'b0100, 1'b0); chk("ov_o1", bus.ovf, 1);
    cycle(1'b0, 4'b0000, 1'b1); chk("ov_i1", dut_idx(), 1); chk("ov_v1", bus.valid, 1);
    cycle(1'b0, 4'b0000, 1'b1); chk("ov_v2", bus.valid, 0); chk("ov_o2", bus.ovf, 1);
    cycle(1'b0, 4'b0000, 1'b1); chk("ov_v3", bus.valid, 0); chk("ov_o3", bus.ovf, 1);
    do_reset();

    // Set wins over same-edge clear: index 1 served twice, no overflow.
    cycle(1'b1, 4'b0100, 1'b0); chk("sw_v0", bus.valid, 0);
    cycle(1'b1, 4'b0100, 1'b0); chk("sw_i1", dut_idx(), 1); chk("sw_o1", bus.ovf, 0);
    cycle(1'b0, 4'b0000, 1'b1); chk("sw_v2", bus.valid, 1); chk("sw_i2", dut_idx(), 1);
    cycle(1'b0, 4'b0000, 1'b1); chk("sw_v3", bus.valid, 0); chk("sw_o3", bus.ovf, 0);

    // Asynchronous reset between edges with valid=1 and pend=1110.
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 4'b1110, 1'b0); chk("ar_pre", bus.valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", bus.valid, 0);
    chk("ar_idx",   dut_idx(), 0);
    chk("ar_ovf",   bus.ovf,   0);
    bus.en = 1'b1; bus.in = 4'b1111; bus.ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0; bus.in = 4'b0000;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, 4'b0000, 1'b1);
      chk("ar_after", bus.valid, 0);
    end

    // Random traffic against the model, with periodic resets to re-arm ovf.
    for (int n = 0; n < 400; n++) begin
      logic       e, r;
      logic [0:3] i;
      logic [3:0] rnd;
      if (n % 80 == 0) do_reset();
      rnd = 4'($urandom);
      e = 1'($urandom_range(0, 1));
      i = ($urandom_range(0, 2) == 0) ? rnd : 4'b0000;
      r = ($urandom_range(0, 3) != 0);
      cycle(e, i, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/encoder_4_2_seq.md
ENCODER_4_2_SEQ -- requirements
Module: encoder_4_2_seq

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  event-capture enable; when 0, in is ignored.
REQ-005 in  input  [0:3]  event lines; bit k set = event for index k.
REQ-006 a  output  1  encoded index LSB (index k = {b,a}); registered.
REQ-007 b  output  1  encoded index MSB; registered.
REQ-008 valid  output  1  {b,a} holds a served index.
REQ-009 ready  input  1  consumer accepts {b,a} when valid & ready at a rising edge.
REQ-010 ovf  output  1  sticky overflow: an event was lost.

Function
REQ-011 Internal pending mask pend[0:3] SHALL record captured events not yet served.
REQ-012 Capture: at each edge with en=1, pend[k] SHALL be set for every in[k]=1; with en=0, in SHALL have no effect.
REQ-013 Selection SHALL be fixed-priority from registered pend only: lowest set index k wins (0 highest).
REQ-014 Load condition: load = (valid=0 | ready=1) & (pend != 0).
REQ-015 On load, {b,a} SHALL take the selected index, valid SHALL be 1, and pend[k] SHALL be cleared at the same edge.
REQ-016 If in[k]=1 with en=1 at the same edge pend[k] is cleared by load, the set SHALL win (new event stays pending).
REQ-017 Handshake: while valid=1 & ready=0, {b,a} and valid SHALL hold stable.
REQ-018 Accept with valid & ready & pend=0: valid SHALL go to 0 at that edge; {b,a} SHALL hold last value.
REQ-019 Accept with valid & ready & pend!=0: the next index SHALL load at the same edge (back-to-back, one per cycle, no bubble).
REQ-020 Latency: event on in at edge N SHALL appear as valid=1 with its index after edge N+1 when no higher-priority index is pending and the output stage is free.
REQ-021 FSM: IDLE (valid=0) -> HOLD on load; HOLD -> HOLD on stall or accept-with-load; HOLD -> IDLE on accept with pend=0. No other states.
REQ-022 Overflow: ovf SHALL be set at an edge where en=1, in[k]=1, pend[k]=1 and pend[k] is not cleared at that edge; ovf SHALL stay 1 until reset; the duplicate event is merged (pend[k] remains 1).
REQ-023 Multi-hot in SHALL be legal; all set bits captured in one edge and served in ascending index order on successive loads.
REQ-024 ready while valid=0 SHALL have no effect.

Reset
REQ-025 While rst_n=0: pend=0, a=0, b=0, valid=0, ovf=0, FSM=IDLE, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all pending and held indices immediately; no event captured during reset SHALL be served after release.
REQ-027 First capture SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-028 Single event: en=1, in=0010 (bit 2) one cycle, ready=1 -> after next edge valid=1, {b,a}=10; one cycle later valid=0.
REQ-029 Multi-hot with stall: in=1011 (bits 0,2,3) one cycle, ready=0 for 3 cycles then 1 -> {b,a}=00 held 3+ cycles, then 10, 11 on consecutive cycles, then valid=0.
REQ-030 Priority override: pend holds 3, in=1000 (bit 0) while output stalled -> after accept, next served {b,a}=00 before 11.
REQ-031 Overflow: in=0100 (bit 1) with ready=0, then in=0100 again while pend[1]=1 -> ovf=1 and stays 1; index 1 served exactly once.
REQ-032 Set-wins: index 1 loading at edge N with in[1]=1 at edge N -> index 1 served twice, ovf=0.
REQ-033 Async reset: rst_n low between edges with valid=1, pend=1110 -> valid, a, b, ovf, pend zero immediately; after release with in=0, valid stays 0.
